pin_in_cond: RTL and testbench

//  Input-direction counterpart of the bidir pin buffers: conditions the raw io pins before they reach the core.
//  Per pin: metastability synchroniser, optional glitch filter, rise/fall pulses, sticky event flags.

---
 rtl/pin_in_cond_if.sv | 27 ++
 rtl/pin_in_cond.sv | 79 +++++++
 tb/tb_pin_in_cond.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/pin_in_cond_if.sv
// rtl/pin_in_cond_if.sv - pin conditioner bus: raw pins and controls in, conditioned levels and events out
interface pin_in_cond_if #(
    parameter int PINS   = 32,
    parameter int FILT_W = 4
);
    logic [PINS-1:0]   io_raw;
    logic [PINS-1:0]   filt_en;
    logic [FILT_W-1:0] filt_len;
    logic [PINS-1:0]   evt_rise_en;
    logic [PINS-1:0]   evt_fall_en;
    logic [PINS-1:0]   evt_clr;
    logic [PINS-1:0]   pin_in;
    logic [PINS-1:0]   pin_rise;
    logic [PINS-1:0]   pin_fall;
    logic [PINS-1:0]   evt_flag;
    logic              evt_any;

    modport master (
        output io_raw, filt_en, filt_len, evt_rise_en, evt_fall_en, evt_clr,
        input  pin_in, pin_rise, pin_fall, evt_flag, evt_any
    );

    modport slave (
        input  io_raw, filt_en, filt_len, evt_rise_en, evt_fall_en, evt_clr,
        output pin_in, pin_rise, pin_fall, evt_flag, evt_any
    );
endinterface

// File: rtl/pin_in_cond.sv
// rtl/pin_in_cond.sv - per-pin synchroniser, glitch filter, edge pulses and sticky event flags
module pin_in_cond #(
    parameter int PINS        = 32,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_W      = 4
) (
    input  logic          clk_cog,
    input  logic          nres,
    pin_in_cond_if.slave  bus
);
    localparam logic [FILT_W:0]   LEN_ONE = 1;
    localparam logic [FILT_W-1:0] CNT_ONE = 1;

    logic [PINS-1:0]   r_sync [SYNC_STAGES];
    logic [FILT_W-1:0] r_cnt  [PINS];
    logic [PINS-1:0]   r_pin;
    logic [PINS-1:0]   r_rise;
    logic [PINS-1:0]   r_fall;
    logic [PINS-1:0]   r_flag;

    logic [PINS-1:0]   w_s;
    logic [FILT_W:0]   w_len;
    logic [FILT_W-1:0] w_cnt_nxt [PINS];
    logic [PINS-1:0]   w_pin_nxt;
    logic [PINS-1:0]   w_rise_nxt;
    logic [PINS-1:0]   w_fall_nxt;
    logic [PINS-1:0]   w_flag_nxt;

    assign w_s   = r_sync[SYNC_STAGES-1];
    // A programmed length of 0 behaves like 1 so the filter never stalls a pin.
    assign w_len = (bus.filt_len == '0) ? LEN_ONE : {1'b0, bus.filt_len};

    always_comb begin
        w_pin_nxt = r_pin;
        for (int i = 0; i < PINS; i++) begin
            w_cnt_nxt[i] = '0;
            if (!bus.filt_en[i]) begin
                w_pin_nxt[i] = w_s[i];
            end else if (w_s[i] != r_pin[i]) begin
                // Compare with >= so a length lowered mid-count accepts immediately.
                if (({1'b0, r_cnt[i]} + LEN_ONE) >= w_len) begin
                    w_pin_nxt[i] = w_s[i];
                end else begin
                    w_cnt_nxt[i] = r_cnt[i] + CNT_ONE;
                end
            end
        end
        w_rise_nxt = w_pin_nxt & ~r_pin;
        w_fall_nxt = ~w_pin_nxt & r_pin;
        // Set wins over clear so an event arriving with evt_clr is never lost.
        w_flag_nxt = (w_rise_nxt & bus.evt_rise_en) | (w_fall_nxt & bus.evt_fall_en)
                   | (r_flag & ~bus.evt_clr);
    end

    always_ff @(posedge clk_cog) begin
        if (!nres) begin
            for (int k = 0; k < SYNC_STAGES; k++) r_sync[k] <= '0;
            for (int i = 0; i < PINS; i++) r_cnt[i] <= '0;
            r_pin  <= '0;
            r_rise <= '0;
            r_fall <= '0;
            r_flag <= '0;
        end else begin
            r_sync[0] <= bus.io_raw;
            for (int k = 1; k < SYNC_STAGES; k++) r_sync[k] <= r_sync[k-1];
            for (int i = 0; i < PINS; i++) r_cnt[i] <= w_cnt_nxt[i];
            r_pin  <= w_pin_nxt;
            r_rise <= w_rise_nxt;
            r_fall <= w_fall_nxt;
            r_flag <= w_flag_nxt;
        end
    end

    assign bus.pin_in   = r_pin;
    assign bus.pin_rise = r_rise;
    assign bus.pin_fall = r_fall;
    assign bus.evt_flag = r_flag;
    assign bus.evt_any  = |r_flag;
endmodule

// File: tb/tb_pin_in_cond.sv
// tb/tb_pin_in_cond.sv - randomized bench for pin_in_cond against a run-length reference model
module tb_pin_in_cond;
    localparam int PINS = 32;
    localparam int SYNC = 2;
    localparam int FW   = 4;

    logic clk;
    logic nres;
    int   n_tests;
    int   n_fail;

    pin_in_cond_if #(.PINS(PINS), .FILT_W(FW)) bus ();

    pin_in_cond #(.PINS(PINS), .SYNC_STAGES(SYNC), .FILT_W(FW)) dut (
        .clk_cog (clk),
        .nres    (nres),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: sync chain as a FIFO of past samples, filter as "consecutive differing cycles".
    logic [31:0] m_q [$];
    int          m_run [PINS];
    logic [31:0] m_pin, m_rise, m_fall, m_flag;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            if (n_fail <= 20) $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        repeat (SYNC) m_q.push_back(32'h0);
        for (int i = 0; i < PINS; i++) m_run[i] = 0;
        m_pin = '0; m_rise = '0; m_fall = '0; m_flag = '0;
    endtask

    task automatic step();
        logic [31:0] s;
        logic [31:0] np;
        int          len;
        @(posedge clk);
        if (!nres) begin
            model_reset();
        end else begin
            s = m_q[0];
            void'(m_q.pop_front());
            m_q.push_back(bus.io_raw);
            len = (bus.filt_len == 0) ? 1 : int'(bus.filt_len);
            np  = m_pin;
            for (int i = 0; i < PINS; i++) begin
                if (!bus.filt_en[i]) begin
                    np[i] = s[i];
                    m_run[i] = 0;
                end else if (s[i] == m_pin[i]) begin
                    m_run[i] = 0;
                end else begin
                    m_run[i]++;
                    if (m_run[i] >= len) begin
                        np[i] = s[i];
                        m_run[i] = 0;
                    end
                end
            end
            m_rise = np & ~m_pin;
            m_fall = ~np & m_pin;
            m_flag = (m_rise & bus.evt_rise_en) | (m_fall & bus.evt_fall_en) | (m_flag & ~bus.evt_clr);
            m_pin  = np;
        end
        #1;
        check_eq("pin_in",   bus.pin_in,   m_pin);
        check_eq("pin_rise", bus.pin_rise, m_rise);
        check_eq("pin_fall", bus.pin_fall, m_fall);
        check_eq("evt_flag", bus.evt_flag, m_flag);
        check_eq("evt_any",  {31'h0, bus.evt_any}, {31'h0, |m_flag});
    endtask

    function automatic logic [31:0] sparse_mask(input int p);
        logic [31:0] m;
        m = '0;
        for (int i = 0; i < PINS; i++) m[i] = ($urandom_range(p - 1) == 0);
        return m;
    endfunction

    initial begin
        int p;
        n_tests = 0;
        n_fail  = 0;
        model_reset();
        nres = 1'b0;
        bus.io_raw = '0; bus.filt_en = '0; bus.filt_len = '0;
        bus.evt_rise_en = '0; bus.evt_fall_en = '0; bus.evt_clr = '0;
        repeat (3) step();
        nres = 1'b1;
        repeat (3) step();

        // Bypass latency: level appears at the third edge after the change.
        bus.io_raw[0] = 1'b1;
        step(); step();
        check_eq("bypass_early", {31'h0, bus.pin_in[0]}, 32'h0);
        step();
        check_eq("bypass_in",   {31'h0, bus.pin_in[0]},   32'h1);
        check_eq("bypass_rise", {31'h0, bus.pin_rise[0]}, 32'h1);
        bus.io_raw[0] = 1'b0;
        repeat (4) step();

        // Filter with length 4: a 3-cycle glitch is dropped, a 4-cycle pulse passes.
        bus.filt_en[5] = 1'b1; bus.filt_len = 4'd4;
        bus.io_raw[5] = 1'b1; repeat (3) step(); bus.io_raw[5] = 1'b0; repeat (6) step();
        check_eq("glitch_drop", {31'h0, bus.pin_in[5]}, 32'h0);
        bus.io_raw[5] = 1'b1; repeat (6) step();
        check_eq("glitch_pass", {31'h0, bus.pin_in[5]}, 32'h1);
        bus.io_raw[5] = 1'b0; repeat (8) step();

        // Randomized segments: filter config, toggle density, enables, clears, resets.
        for (int seg = 0; seg < 70; seg++) begin
            case ($urandom_range(3))
                0: bus.filt_en = '0;
                1: bus.filt_en = '1;
                default: bus.filt_en = $urandom;
            endcase
            bus.filt_len    = 4'($urandom_range(($urandom_range(3) == 0) ? 15 : 6));
            bus.evt_rise_en = $urandom;
            bus.evt_fall_en = $urandom;
            case ($urandom_range(3))
                0: p = 2;
                1: p = 4;
                2: p = 8;
                default: p = 16;
            endcase
            for (int c = 0; c < 30; c++) begin
                bus.io_raw  = bus.io_raw ^ sparse_mask(p);
                bus.evt_clr = sparse_mask(12);
                if ($urandom_range(7) == 0) bus.filt_len = 4'($urandom_range(8));
                if ($urandom_range(15) == 0) bus.filt_en = bus.filt_en ^ sparse_mask(4);
                nres = ($urandom_range(150) != 0);
                step();
            end
            nres = 1'b1;
        end

        // All pins rise together with rise events enabled, then a partial clear.
        bus.evt_clr = '1; bus.filt_en = '0; bus.io_raw = '0; bus.evt_rise_en = '1;
        repeat (5) step();
        bus.evt_clr = '0; bus.io_raw = '1;
        repeat (3) step();
        check_eq("wide_rise", bus.pin_rise, 32'hFFFF_FFFF);
        check_eq("wide_flag", bus.evt_flag, 32'hFFFF_FFFF);
        bus.evt_clr = 32'h0000_FFFF;
        step();
        check_eq("wide_half", bus.evt_flag, 32'hFFFF_0000);
        check_eq("wide_any",  {31'h0, bus.evt_any}, 32'h1);
        bus.evt_clr = '1;
        step();
        check_eq("all_clr", {31'h0, bus.evt_any}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
